// File: rtl/io_timer_port_pkg.sv
// rtl/io_timer_port_pkg.sv - register map, bit indices and shared types for io_timer_port
package io_timer_port_pkg;

    localparam logic [3:0] IO_WINDOW = 4'hD;

    localparam logic [3:0] REG_PORT = 4'd0;
    localparam logic [3:0] REG_DDR  = 4'd1;
    localparam logic [3:0] REG_TLO  = 4'd2;
    localparam logic [3:0] REG_THI  = 4'd3;
    localparam logic [3:0] REG_CTRL = 4'd4;
    localparam logic [3:0] REG_STAT = 4'd5;
    localparam logic [3:0] REG_PRE  = 4'd6;

    localparam int CTRL_CONT   = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_TFLAG  = 0;
    localparam int STAT_RUN    = 1;

    typedef struct packed {
        logic irq_en;
        logic cont;
    } ctrl_t;

endpackage

// File: rtl/io_timer_port_if.sv
// rtl/io_timer_port_if.sv - CPU-side register bus of io_timer_port
interface io_timer_port_if;
    logic       io_sel;
    logic [3:0] address;
    logic       rw;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output io_sel, address, rw, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  io_sel, address, rw, data_in,
        output data_out, data_oe
    );
endinterface

// File: rtl/io_timer_port_countdown_timer.sv
// rtl/io_timer_port_countdown_timer.sv - 16-bit down-counter with reload latch; prescaler under IO_TIMER_PRESCALER_EN
module io_countdown_timer #(
    parameter logic [15:0] RESET_LATCH = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        latch_lo_we,
    input  logic [7:0]  latch_lo,
    input  logic        load,
    input  logic [7:0]  load_value,
    input  logic        cont,
    input  logic        clr_flag,
    input  logic [7:0]  pre,
    output logic [15:0] counter,
    output logic        tflag,
    output logic        run
);

    logic [15:0] latch_q, latch_d;
    logic [15:0] counter_q, counter_d;
    logic        tflag_q, tflag_d;
    logic        run_q, run_d;
    logic        tick;

`ifdef IO_TIMER_PRESCALER_EN
    logic [7:0] pre_cnt_q, pre_cnt_d;

    // >= rather than == so lowering PRE mid-count cannot strand the divider
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        tick      = 1'b0;
        if (load) begin
            pre_cnt_d = 8'd0;
        end else if (run_q) begin
            if (pre_cnt_q >= pre) begin
                pre_cnt_d = 8'd0;
                tick      = 1'b1;
            end else begin
                pre_cnt_d = pre_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pre_cnt_q <= 8'd0;
        else       pre_cnt_q <= pre_cnt_d;
    end
`else
    logic unused_pre;
    assign unused_pre = ^pre;
    assign tick       = run_q;
`endif

    // Order matters: expiry set beats a flag clear, a load beats everything
    always_comb begin
        latch_d   = latch_q;
        counter_d = counter_q;
        tflag_d   = tflag_q;
        run_d     = run_q;
        if (latch_lo_we) latch_d[7:0] = latch_lo;
        if (clr_flag)    tflag_d = 1'b0;
        if (tick) begin
            if (counter_q != 16'd0) begin
                counter_d = counter_q - 16'd1;
            end else begin
                tflag_d = 1'b1;
                if (cont) counter_d = latch_q;
                else      run_d     = 1'b0;
            end
        end
        if (load) begin
            latch_d[15:8] = load_value;
            counter_d     = {load_value, latch_q[7:0]};
            run_d         = 1'b1;
            tflag_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q   <= RESET_LATCH;
            counter_q <= 16'd0;
            tflag_q   <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            latch_q   <= latch_d;
            counter_q <= counter_d;
            tflag_q   <= tflag_d;
            run_q     <= run_d;
        end
    end

    assign counter = counter_q;
    assign tflag   = tflag_q;
    assign run     = run_q;

endmodule

// File: rtl/io_timer_port.sv
// rtl/io_timer_port.sv - GPIO port plus countdown timer with IRQ; PRE register enabled by IO_TIMER_PRESCALER_EN
module io_timer_port
    import io_timer_port_pkg::*;
#(
    parameter logic [15:0] RESET_LATCH = 16'hFFFF,
    parameter int          NUM_REGS    = 7
) (
    input  logic             clk,
    input  logic             reset,
    io_timer_port_if.slave   bus,
    input  logic [7:0]       port_in,
    output logic [7:0]       port_out,
    output logic [7:0]       port_dir,
    output logic             irq_n
);

    logic [7:0]  port_out_q, port_dir_q;
    ctrl_t       ctrl_q;
    logic [7:0]  pre_val;
    logic        reg_ok, wr;
    logic        we_port, we_ddr, we_tlo, we_thi, we_ctrl, we_stat, we_pre;
    logic [15:0] counter;
    logic        tflag, run;

    // Offsets at or above NUM_REGS are holes: no write effect, read as zero
    assign reg_ok  = 32'(bus.address) < NUM_REGS;
    assign wr      = ~bus.io_sel & ~bus.rw & reg_ok;
    assign we_port = wr && (bus.address == REG_PORT);
    assign we_ddr  = wr && (bus.address == REG_DDR);
    assign we_tlo  = wr && (bus.address == REG_TLO);
    assign we_thi  = wr && (bus.address == REG_THI);
    assign we_ctrl = wr && (bus.address == REG_CTRL);
    assign we_stat = wr && (bus.address == REG_STAT);
    assign we_pre  = wr && (bus.address == REG_PRE);

    always_ff @(posedge clk) begin
        if (reset) begin
            port_out_q <= 8'h00;
            port_dir_q <= 8'h00;
            ctrl_q     <= '0;
        end else begin
            if (we_port) port_out_q <= bus.data_in;
            if (we_ddr)  port_dir_q <= bus.data_in;
            if (we_ctrl) ctrl_q     <= ctrl_t'(bus.data_in[1:0]);
        end
    end

`ifdef IO_TIMER_PRESCALER_EN
    logic [7:0] pre_q;
    always_ff @(posedge clk) begin
        if (reset)       pre_q <= 8'h00;
        else if (we_pre) pre_q <= bus.data_in;
    end
    assign pre_val = pre_q;
`else
    logic unused_we_pre;
    assign unused_we_pre = we_pre;
    assign pre_val       = 8'h00;
`endif

    io_countdown_timer #(
        .RESET_LATCH (RESET_LATCH)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .latch_lo_we (we_tlo),
        .latch_lo    (bus.data_in),
        .load        (we_thi),
        .load_value  (bus.data_in),
        .cont        (ctrl_q.cont),
        .clr_flag    (we_stat & bus.data_in[STAT_TFLAG]),
        .pre         (pre_val),
        .counter     (counter),
        .tflag       (tflag),
        .run         (run)
    );

    always_comb begin
        bus.data_out = 8'h00;
        if (reg_ok) begin
            case (bus.address)
                REG_PORT: bus.data_out = (port_dir_q & port_out_q) | (~port_dir_q & port_in);
                REG_DDR:  bus.data_out = port_dir_q;
                REG_TLO:  bus.data_out = counter[7:0];
                REG_THI:  bus.data_out = counter[15:8];
                REG_CTRL: bus.data_out = {6'b0, ctrl_q};
                REG_STAT: bus.data_out = {6'b0, run, tflag};
                REG_PRE:  bus.data_out = pre_val;
                default:  bus.data_out = 8'h00;
            endcase
        end
    end

    assign bus.data_oe = ~bus.io_sel & bus.rw;
    assign port_out    = port_out_q;
    assign port_dir    = port_dir_q;
    assign irq_n       = ~(tflag & ctrl_q.irq_en);

endmodule

// File: tb/tb_io_timer_port.sv
// tb/tb_io_timer_port.sv - directed self-checking bench for io_timer_port
module tb_io_timer_port;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] port_in;
    logic [7:0] port_out, port_dir;
    logic       irq_n;
    int         checks   = 0;
    int         failures = 0;

    io_timer_port_if bus ();

    io_timer_port #(
        .RESET_LATCH (16'hFFFF),
        .NUM_REGS    (7)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .port_in  (port_in),
        .port_out (port_out),
        .port_dir (port_dir),
        .irq_n    (irq_n)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.io_sel  = 1'b0;
        bus.rw      = 1'b0;
        bus.address = a;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.io_sel = 1'b1;
        bus.rw     = 1'b1;
    endtask

    task automatic chk_rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        bus.io_sel  = 1'b0;
        bus.rw      = 1'b1;
        bus.address = a;
        #1;
        check_eq(tag, {8'h00, bus.data_out}, {8'h00, exp});
        bus.io_sel = 1'b1;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        bus.io_sel  = 1'b1;
        bus.rw      = 1'b1;
        bus.address = 4'h0;
        bus.data_in = 8'h00;
        port_in     = 8'h3C;
        wait_edges(2);
        reset = 1'b0;

        check_eq("rst_irq_n", {15'd0, irq_n}, 16'd1);
        check_eq("rst_port_out", {8'h00, port_out}, 16'h0000);
        check_eq("rst_port_dir", {8'h00, port_dir}, 16'h0000);
        chk_rd("rst_stat", 4'd5, 8'h00);
        chk_rd("rst_tlo", 4'd2, 8'h00);
        chk_rd("rst_ctrl", 4'd4, 8'h00);

        bus.io_sel = 1'b0; bus.rw = 1'b1; #1;
        check_eq("oe_read", {15'd0, bus.data_oe}, 16'd1);
        bus.io_sel = 1'b1; #1;
        check_eq("oe_idle", {15'd0, bus.data_oe}, 16'd0);

        // GPIO mixing
        bus_wr(4'd1, 8'h0F);
        bus_wr(4'd0, 8'hA5);
        chk_rd("port_read", 4'd0, 8'h35);
        chk_rd("ddr_read", 4'd1, 8'h0F);
        check_eq("port_out", {8'h00, port_out}, 16'h00A5);
        check_eq("port_dir", {8'h00, port_dir}, 16'h000F);

        // one-shot, N=3 expires 4 clks after THI edge
        bus_wr(4'd4, 8'h02);
        bus_wr(4'd2, 8'h03);
        bus_wr(4'd3, 8'h00);
        chk_rd("os_stat_run", 4'd5, 8'h02);
        chk_rd("os_tlo_load", 4'd2, 8'h03);
        wait_edges(3);
        check_eq("os_irq_early", {15'd0, irq_n}, 16'd1);
        wait_edges(1);
        check_eq("os_irq_fire", {15'd0, irq_n}, 16'd0);
        chk_rd("os_stat_done", 4'd5, 8'h01);
        chk_rd("os_tlo_zero", 4'd2, 8'h00);
        chk_rd("os_thi_zero", 4'd3, 8'h00);
        wait_edges(2);
        chk_rd("os_hold_zero", 4'd2, 8'h00);

        // continuous, latch=0002 -> period 3
        bus_wr(4'd5, 8'h01);
        check_eq("clr_irq", {15'd0, irq_n}, 16'd1);
        bus_wr(4'd4, 8'h03);
        bus_wr(4'd2, 8'h02);
        bus_wr(4'd3, 8'h00);
        wait_edges(3);
        check_eq("ct_fire1", {15'd0, irq_n}, 16'd0);
        bus_wr(4'd5, 8'h01);
        check_eq("ct_cleared", {15'd0, irq_n}, 16'd1);
        wait_edges(1);
        check_eq("ct_still_clr", {15'd0, irq_n}, 16'd1);
        wait_edges(1);
        check_eq("ct_fire2", {15'd0, irq_n}, 16'd0);

        // STAT clear collides with expiry: set wins
        wait_edges(2);
        bus_wr(4'd5, 8'h01);
        check_eq("col_clr_irq", {15'd0, irq_n}, 16'd0);
        chk_rd("col_clr_stat", 4'd5, 8'h03);

        // THI write collides with expiry: load wins
        wait_edges(2);
        bus_wr(4'd3, 8'h01);
        chk_rd("col_thi_stat", 4'd5, 8'h02);
        chk_rd("col_thi_tlo", 4'd2, 8'h02);
        chk_rd("col_thi_thi", 4'd3, 8'h01);
        check_eq("col_thi_irq", {15'd0, irq_n}, 16'd1);

        // reset mid-run with IRQ pending
        bus_wr(4'd2, 8'h00);
        bus_wr(4'd3, 8'h00);
        wait_edges(1);
        check_eq("pre_rst_irq", {15'd0, irq_n}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("mid_rst_irq", {15'd0, irq_n}, 16'd1);
        chk_rd("mid_rst_stat", 4'd5, 8'h00);
        chk_rd("mid_rst_tlo", 4'd2, 8'h00);
        chk_rd("mid_rst_ctrl", 4'd4, 8'h00);
        bus_wr(4'd3, 8'h12);
        chk_rd("rst_latch_lo", 4'd2, 8'hFF);
        chk_rd("rst_latch_hi", 4'd3, 8'h12);

        // unimplemented offsets
        bus_wr(4'd7, 8'hFF);
        chk_rd("off7", 4'd7, 8'h00);
        chk_rd("offF", 4'd15, 8'h00);

`ifdef IO_TIMER_PRESCALER_EN
        bus_wr(4'd6, 8'h01);
        chk_rd("pre_rd", 4'd6, 8'h01);
        bus_wr(4'd4, 8'h02);
        bus_wr(4'd2, 8'h01);
        bus_wr(4'd3, 8'h00);
        wait_edges(3);
        check_eq("pre_irq_early", {15'd0, irq_n}, 16'd1);
        wait_edges(1);
        check_eq("pre_irq_fire", {15'd0, irq_n}, 16'd0);
`else
        bus_wr(4'd6, 8'hFF);
        chk_rd("pre_absent", 4'd6, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
